// File: rtl/ped_button_conditioner_if.sv
// Pedestrian button conditioner bus: raw buttons and controller handshake in, latched requests out.
interface ped_button_conditioner_if #(
    parameter int NUM_BUTTONS = 4
);
    logic                   i_maintenance;
    logic [NUM_BUTTONS-1:0] i_ped_buttons;
    logic                   i_ped_served;
    logic                   o_ped_request;
    logic [NUM_BUTTONS-1:0] o_wait_lamps;
    logic [NUM_BUTTONS-1:0] o_stuck;

    modport master (
        output i_maintenance, i_ped_buttons, i_ped_served,
        input  o_ped_request, o_wait_lamps, o_stuck
    );

    modport slave (
        input  i_maintenance, i_ped_buttons, i_ped_served,
        output o_ped_request, o_wait_lamps, o_stuck
    );
endinterface

// File: rtl/ped_button_conditioner.sv
// Synchronises, debounces and latches pedestrian buttons into crossing requests, with stuck-button withdrawal.
// Raw edge to WAIT lamp is DEBOUNCE_CYCLES+3 clocks; no backpressure, requests are level-latched until served.
module ped_button_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int CYCLES_PER_SEC  = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_SECS      = 30
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    ped_button_conditioner_if.slave   bus
);
    localparam int STUCK_CYCLES = STUCK_SECS * CYCLES_PER_SEC;
    localparam bit STUCK_EN     = (STUCK_SECS != 0);
    localparam int DW           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW           = (STUCK_CYCLES > 0) ? $clog2(STUCK_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = STUCK_EN ? HW'(STUCK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, PRESSED, STUCK} btn_state_e;

    logic [NUM_BUTTONS-1:0] sync1, sync2, stable;
    logic [DW-1:0]          db_cnt [NUM_BUTTONS];
    btn_state_e             state [NUM_BUTTONS];
    btn_state_e             state_nxt [NUM_BUTTONS];
    logic [HW-1:0]          hold [NUM_BUTTONS];
    logic [HW-1:0]          hold_nxt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] press_evt, stuck_evt, stuck_vec;
    logic [NUM_BUTTONS-1:0] wait_q, wait_nxt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= bus.i_ped_buttons;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state[i] <= IDLE;
                hold[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state[i] <= state_nxt[i];
                hold[i]  <= hold_nxt[i];
            end
        end
    end

    // A release seen on the threshold cycle is checked first, so the fall wins over stuck.
    always_comb begin
        press_evt = '0;
        stuck_evt = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold[i];
            case (state[i])
                IDLE: begin
                    if (stable[i]) begin
                        state_nxt[i] = PRESSED;
                        hold_nxt[i]  = '0;
                        press_evt[i] = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!stable[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (STUCK_EN && hold[i] == HOLD_LAST) begin
                        state_nxt[i] = STUCK;
                        stuck_evt[i] = 1'b1;
                    end else if (hold[i] != '1) begin
                        hold_nxt[i] = hold[i] + HW'(1);
                    end
                end
                STUCK: begin
                    if (!stable[i]) state_nxt[i] = IDLE;
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // A press on the serving edge survives; maintenance overrides everything.
    always_comb begin
        wait_nxt = bus.i_ped_served ? '0 : wait_q;
        wait_nxt = (wait_nxt | press_evt) & ~stuck_evt;
        if (bus.i_maintenance) wait_nxt = '0;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) wait_q <= '0;
        else          wait_q <= wait_nxt;
    end

    always_comb begin
        stuck_vec = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) stuck_vec[i] = (state[i] == STUCK);
    end

    assign bus.o_wait_lamps  = wait_q;
    assign bus.o_ped_request = |wait_q;
    assign bus.o_stuck       = stuck_vec;
endmodule

// File: tb/tb_ped_button_conditioner.sv
// Bench for ped_button_conditioner: cycle-accurate reference model plus directed scenarios with literal expectations.
module tb_ped_button_conditioner;
    localparam int NB  = 4;
    localparam int CPS = 16;
    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int SC  = SS * CPS;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ped_button_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

    ped_button_conditioner #(
        .NUM_BUTTONS(NB), .CYCLES_PER_SEC(CPS), .DEBOUNCE_CYCLES(DB), .STUCK_SECS(SS)
    ) dut (
        .clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync is a 2-sample delay, debounce is "last DB samples all
    // disagree with the accepted level", stuck is elapsed edges since press.
    logic [NB-1:0] m_stable, m_wait, m_held, m_stuck, raw_d1, raw_d2;
    logic [NB-1:0] sh [DB];
    int            m_press_t [NB];
    int            cyc;

    task automatic model_clear();
        m_stable = '0; m_wait = '0; m_held = '0; m_stuck = '0;
        raw_d1 = '0; raw_d2 = '0;
        for (int k = 0; k < DB; k++) sh[k] = '0;
        for (int i = 0; i < NB; i++) m_press_t[i] = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] press, stk;
        logic          flip;
        press = '0;
        stk   = '0;
        for (int i = 0; i < NB; i++) begin
            if (!m_held[i] && m_stable[i]) begin
                m_held[i] = 1'b1; m_press_t[i] = cyc; press[i] = 1'b1;
            end else if (m_held[i] && !m_stable[i]) begin
                m_held[i] = 1'b0; m_stuck[i] = 1'b0;
            end else if (m_held[i] && !m_stuck[i] && SC > 0 && (cyc - m_press_t[i]) == SC) begin
                m_stuck[i] = 1'b1; stk[i] = 1'b1;
            end
        end
        if (bus.i_ped_served) m_wait = '0;
        m_wait = (m_wait | press) & ~stk;
        if (bus.i_maintenance) m_wait = '0;
        for (int k = DB - 1; k > 0; k--) sh[k] = sh[k-1];
        sh[0] = raw_d2;
        for (int i = 0; i < NB; i++) begin
            flip = 1'b1;
            for (int k = 0; k < DB; k++) if (sh[k][i] == m_stable[i]) flip = 1'b0;
            if (flip) m_stable[i] = ~m_stable[i];
        end
        raw_d2 = raw_d1;
        raw_d1 = bus.i_ped_buttons;
        cyc++;
    endtask

    initial begin
        cyc = 0;
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_lamps", bus.o_wait_lamps, m_wait);
            check("model_stuck", bus.o_stuck, m_stuck);
            check("model_req", {3'b0, bus.o_ped_request}, {3'b0, |m_wait});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [NB-1:0] lamps, input logic [NB-1:0] stk);
        check({name, "_lamps"}, bus.o_wait_lamps, lamps);
        check({name, "_stuck"}, bus.o_stuck, stk);
        check({name, "_req"}, {3'b0, bus.o_ped_request}, {3'b0, |lamps});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_maintenance = 1'b0;
        bus.i_ped_buttons = '0;
        bus.i_ped_served  = 1'b0;
        tick(5);
        lit("reset_hold", 4'b0000, 4'b0000);
        #2 rst_n = 1'b1;
        tick(2);
        lit("reset_release", 4'b0000, 4'b0000);

        // Clean press on button 0, released after 10 cycles
        bus.i_ped_buttons = 4'b0001;
        tick(6);
        lit("b0_edge6", 4'b0000, 4'b0000);
        tick(1);
        lit("b0_edge7", 4'b0001, 4'b0000);
        tick(3);
        bus.i_ped_buttons = 4'b0000;
        tick(10);
        lit("b0_after_release", 4'b0001, 4'b0000);
        bus.i_ped_served = 1'b1;
        tick(1);
        bus.i_ped_served = 1'b0;
        lit("b0_served", 4'b0000, 4'b0000);

        // Short glitch on button 1
        bus.i_ped_buttons = 4'b0010;
        tick(3);
        bus.i_ped_buttons = 4'b0000;
        tick(15);
        lit("b1_glitch", 4'b0000, 4'b0000);

        // Bouncing button 2 then steady
        for (int k = 0; k < 8; k++) begin
            bus.i_ped_buttons = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        lit("b2_bouncing", 4'b0000, 4'b0000);
        bus.i_ped_buttons = 4'b0100;
        tick(6);
        lit("b2_edge6", 4'b0000, 4'b0000);
        tick(1);
        lit("b2_edge7", 4'b0100, 4'b0000);
        bus.i_ped_buttons = 4'b0000;
        bus.i_ped_served = 1'b1;
        tick(1);
        bus.i_ped_served = 1'b0;
        tick(10);
        lit("b2_served", 4'b0000, 4'b0000);

        // Stuck button 3
        bus.i_ped_buttons = 4'b1000;
        tick(7);
        lit("b3_edge7", 4'b1000, 4'b0000);
        tick(31);
        lit("b3_edge38", 4'b1000, 4'b0000);
        tick(1);
        lit("b3_edge39", 4'b0000, 4'b1000);
        tick(11);
        bus.i_ped_buttons = 4'b0000;
        tick(6);
        lit("b3_rel_edge6", 4'b0000, 4'b1000);
        tick(1);
        lit("b3_rel_edge7", 4'b0000, 4'b0000);
        tick(10);
        lit("b3_no_request", 4'b0000, 4'b0000);

        // Served on the same edge as a new press on button 1
        bus.i_ped_buttons = 4'b0001;
        tick(7);
        lit("b0_latched", 4'b0001, 4'b0000);
        bus.i_ped_buttons = 4'b0010;
        tick(6);
        bus.i_ped_served = 1'b1;
        tick(1);
        bus.i_ped_served = 1'b0;
        lit("served_vs_press", 4'b0010, 4'b0000);

        // Maintenance clears and drops a press on button 2
        bus.i_maintenance = 1'b1;
        bus.i_ped_buttons = 4'b0110;
        tick(1);
        lit("maint_clear", 4'b0000, 4'b0000);
        tick(10);
        bus.i_maintenance = 1'b0;
        tick(10);
        lit("maint_held", 4'b0000, 4'b0000);
        bus.i_ped_buttons = 4'b0000;
        tick(10);
        lit("maint_released", 4'b0000, 4'b0000);

        // Asynchronous reset mid-request
        bus.i_ped_buttons = 4'b0001;
        tick(8);
        lit("pre_async", 4'b0001, 4'b0000);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 4'b0000, 4'b0000);
        bus.i_ped_buttons = 4'b0000;
        tick(2);
        #2 rst_n = 1'b1;
        tick(3);
        lit("post_async", 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
